beta_fetch_stage: RTL and testbench
===================================

Name: beta_fetch_stage

Overview:
- Instruction fetch stage of the Bourbon 3-stage pipeline; sits upstream of the if-to-dec pipe (pip0) and is gated by the pipeline control unit's fetch enable.
- Owns the program counter and runs a single-outstanding request/grant/rvalid handshake to instruction memory.
- Presents the fetched instruction and its PC to pip0.
- Handles control-hazard redirects from the execute-stage branch/jump unit, including discard of in-flight responses.

Parameters:
- DataWidth, 32, width of PC, address and instruction lines.
- BootAddr, 32'h0000_0000, PC value loaded at reset; bits [1:0] must be 0.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rstn_i  in  1  reset, asynchronous, active-low.
- ifs_fetch_en_i  in  1  fetch enable from pipeline control unit.
- ifs_busy_o  out  1  high while a fetch is in progress (state != IDLE).
- ifs_redirect_i  in  1  control-hazard redirect request from the execute-stage branch/jump unit.
- ifs_redirect_addr_i  in  DataWidth  redirect target PC.
- imem_req_o  out  1  instruction memory request.
- imem_addr_o  out  DataWidth  request address (current PC).
- imem_gnt_i  in  1  request accepted.
- imem_rvalid_i  in  1  response data valid.
- imem_rdata_i  in  DataWidth  response instruction.
- ifs_instr_o  out  DataWidth  last fetched instruction; held until next capture.
- ifs_pc_o  out  DataWidth  PC of ifs_instr_o.
- ifs_valid_o  out  1  one-cycle pulse: new instruction on ifs_instr_o/ifs_pc_o.
- ifs_misaligned_o  out  1  misaligned redirect flag (macro only; otherwise tied 0).

Behaviour:
- Reset (async, rstn_i=0):
  - state=IDLE, pc=BootAddr.
  - ifs_instr_o=32'h0000_0013 (NOP), ifs_pc_o=0, ifs_valid_o=0, ifs_busy_o=0, imem_req_o=0, ifs_misaligned_o=0.
- Outputs: imem_req_o=1 only in REQ; imem_addr_o=pc in all states. ifs_busy_o is combinational from state.
- IDLE:
  - ifs_redirect_i=1 -> pc<=target, stay IDLE. Redirect has priority over fetch_en.
  - Otherwise ifs_fetch_en_i=1 -> REQ.
- REQ:
  - Redirect without gnt -> pc<=target, stay REQ; the new address is presented next cycle.
  - Redirect with gnt -> pc<=target, DISCARD.
  - gnt without redirect -> WAIT.
  - imem_addr_o must be stable while req is high without gnt.
- WAIT:
  - rvalid without redirect -> ifs_instr_o<=rdata, ifs_pc_o<=pc, ifs_valid_o<=1 for one cycle, pc<=pc+4, IDLE.
  - Redirect with rvalid -> data dropped (no valid pulse), pc<=target, IDLE.
  - Redirect without rvalid -> pc<=target, DISCARD.
- DISCARD:
  - rvalid -> data dropped, IDLE.
  - A further redirect here only updates pc.
- PC arithmetic: pc+4 modulo 2^DataWidth (0xFFFF_FFFC wraps to 0x0000_0000). Redirect target bits [1:0] are forced to 0.
- Outstanding requests: at most one; imem_rvalid_i outside WAIT/DISCARD is ignored.
- Latency: fetch_en sampled high at cycle 0 -> req at cycle 1; with gnt at 1 and rvalid at 2, ifs_valid_o is high in cycle 3 with IDLE.
  - Zero-wait-state fetch: 3 cycles enable-to-valid.
  - ifs_busy_o high in cycles 1-2.
- Holding: ifs_instr_o/ifs_pc_o hold between captures regardless of fetch_en. pip0 samples them on ifs_valid_o.
- Reset mid-operation: returns to IDLE at once. A pending memory response arriving after reset release in IDLE is ignored.

Optional Feature:
- Macro: BETA_FETCH_MISALIGN_CHECK_EN.
- Defined:
  - A redirect with target[1:0]!=0 sets ifs_misaligned_o=1 (sticky) and loads pc with the target's bits [1:0] cleared.
  - While the flag is set, fetch_en is ignored and the block stays IDLE.
  - The next aligned redirect clears the flag and loads pc normally; reset also clears it.
- Undefined: no check, ifs_misaligned_o tied 0, bits [1:0] silently cleared.

Test Plan:
- Reset, fetch_en=1, gnt immediate, rvalid 1 cycle later, rdata=0x00500093 -> imem_addr_o=0x0, ifs_valid_o pulse in cycle 3, ifs_instr_o=0x00500093, ifs_pc_o=0x0, next imem_addr_o=0x4.
- gnt withheld 3 cycles -> imem_req_o stays 1, imem_addr_o stable at 0x4, ifs_busy_o=1 throughout, single valid pulse after rvalid.
- Redirect to 0x100 in WAIT, then stale rvalid rdata=0xDEADBEEF -> no valid pulse, instr unchanged; next fetch addr=0x100 and returns ifs_pc_o=0x100.
- Redirect to 0x200 coinciding with rvalid -> data dropped, IDLE, pc=0x200; redirect in REQ without gnt -> next-cycle imem_addr_o=new target.
- BootAddr=0xFFFFFFFC, one fetch -> ifs_pc_o=0xFFFFFFFC, next imem_addr_o=0x0; rstn_i pulsed low in WAIT -> IDLE, imem_req_o=0, pc=BootAddr immediately.
- With BETA_FETCH_MISALIGN_CHECK_EN: redirect to 0x102 -> ifs_misaligned_o=1, fetch_en ignored for 5 cycles; redirect to 0x104 -> flag 0, fetch from 0x104.

Source files
------------

// File: rtl/beta_fetch_stage.sv
// Bourbon instruction fetch stage: owns the PC and runs a single-outstanding req/gnt/rvalid fetch.
// Optional BETA_FETCH_MISALIGN_CHECK_EN: flags misaligned redirect targets and blocks fetch until fixed.
module beta_fetch_stage #(
    parameter int unsigned          DataWidth = 32,
    parameter logic [DataWidth-1:0] BootAddr  = '0
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 ifs_fetch_en_i,
    output logic                 ifs_busy_o,
    input  logic                 ifs_redirect_i,
    input  logic [DataWidth-1:0] ifs_redirect_addr_i,
    output logic                 imem_req_o,
    output logic [DataWidth-1:0] imem_addr_o,
    input  logic                 imem_gnt_i,
    input  logic                 imem_rvalid_i,
    input  logic [DataWidth-1:0] imem_rdata_i,
    output logic [DataWidth-1:0] ifs_instr_o,
    output logic [DataWidth-1:0] ifs_pc_o,
    output logic                 ifs_valid_o,
    output logic                 ifs_misaligned_o
);
    localparam logic [DataWidth-1:0] NopInstr = DataWidth'(32'h0000_0013);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DISCARD} state_t;

    state_t               state_q;
    logic [DataWidth-1:0] pc_p0;
    logic [DataWidth-1:0] instr_p1;
    logic [DataWidth-1:0] pc_p1;
    logic                 vld_p1;
    logic [DataWidth-1:0] redirect_pc;
    logic                 fetch_block;

    function automatic logic [DataWidth-1:0] pc_inc(input logic [DataWidth-1:0] pc);
        return pc + DataWidth'(4);
    endfunction

    function automatic logic [DataWidth-1:0] word_align(input logic [DataWidth-1:0] a);
        return a & ~DataWidth'(3);
    endfunction

    assign redirect_pc = word_align(ifs_redirect_addr_i);

`ifdef BETA_FETCH_MISALIGN_CHECK_EN
    logic misaligned_q;

    // Sticky until an aligned redirect arrives; fetch stays parked in IDLE meanwhile.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            misaligned_q <= 1'b0;
        end else if (ifs_redirect_i) begin
            misaligned_q <= |ifs_redirect_addr_i[1:0];
        end
    end

    assign fetch_block      = misaligned_q;
    assign ifs_misaligned_o = misaligned_q;
`else
    assign fetch_block      = 1'b0;
    assign ifs_misaligned_o = 1'b0;
`endif

    // p0: PC / request stage
    assign imem_req_o  = (state_q == REQ);
    assign imem_addr_o = pc_p0;
    assign ifs_busy_o  = (state_q != IDLE);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            pc_p0    <= BootAddr;
            instr_p1 <= NopInstr;
            pc_p1    <= '0;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= 1'b0;
            if (ifs_redirect_i) begin
                pc_p0 <= redirect_pc;
            end
            case (state_q)
                IDLE: begin
                    if (!ifs_redirect_i && ifs_fetch_en_i && !fetch_block) begin
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    // Without gnt the request simply re-presents the (possibly redirected) PC.
                    if (imem_gnt_i) begin
                        state_q <= ifs_redirect_i ? DISCARD : WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid_i) begin
                        state_q <= IDLE;
                        if (!ifs_redirect_i) begin
                            instr_p1 <= imem_rdata_i;
                            pc_p1    <= pc_p0;
                            vld_p1   <= 1'b1;
                            pc_p0    <= pc_inc(pc_p0);
                        end
                    end else if (ifs_redirect_i) begin
                        state_q <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (imem_rvalid_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // p1: capture stage presented to pip0
    assign ifs_instr_o = instr_p1;
    assign ifs_pc_o    = pc_p1;
    assign ifs_valid_o = vld_p1;

endmodule

// File: tb/tb_beta_fetch_stage.sv
// Self-checking bench for beta_fetch_stage: vector table of fetches, scoreboard on ifs_valid_o,
// and hand-written redirect / reset / wrap sequences.
module tb_beta_fetch_stage;
    logic        clk = 1'b0;
    logic        rstn, fetch_en, redirect, gnt, rvalid;
    logic [31:0] redirect_addr, rdata;
    logic        busy, req, valid, misaligned;
    logic [31:0] addr, instr, pc;

    logic        w_rstn, w_fetch_en, w_redirect, w_gnt, w_rvalid;
    logic [31:0] w_redirect_addr, w_rdata;
    logic        w_busy, w_req, w_valid, w_misaligned;
    logic [31:0] w_addr, w_instr, w_pc;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int          gnt_wait;
        int          rv_wait;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
    } vec_t;
    vec_t vecs[4];

    always #5 clk = ~clk;

    beta_fetch_stage #(.DataWidth(32), .BootAddr(32'h0000_0000)) dut (
        .clk_i(clk), .rstn_i(rstn), .ifs_fetch_en_i(fetch_en), .ifs_busy_o(busy),
        .ifs_redirect_i(redirect), .ifs_redirect_addr_i(redirect_addr),
        .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
        .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
        .ifs_instr_o(instr), .ifs_pc_o(pc), .ifs_valid_o(valid),
        .ifs_misaligned_o(misaligned)
    );

    beta_fetch_stage #(.DataWidth(32), .BootAddr(32'hFFFF_FFFC)) dut_w (
        .clk_i(clk), .rstn_i(w_rstn), .ifs_fetch_en_i(w_fetch_en), .ifs_busy_o(w_busy),
        .ifs_redirect_i(w_redirect), .ifs_redirect_addr_i(w_redirect_addr),
        .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_gnt_i(w_gnt),
        .imem_rvalid_i(w_rvalid), .imem_rdata_i(w_rdata),
        .ifs_instr_o(w_instr), .ifs_pc_o(w_pc), .ifs_valid_o(w_valid),
        .ifs_misaligned_o(w_misaligned)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every ifs_valid_o pulse must match the oldest expected capture.
    always @(negedge clk) begin
        exp_t e;
        if (valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected_valid: got valid with pc=0x%08h, expected none", pc);
            end else begin
                e = sb.pop_front();
                check("sb_instr", instr, e.instr);
                check("sb_pc", pc, e.pc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic do_fetch(input string tag, input int gnt_wait, input int rv_wait,
                            input logic [31:0] data, input logic [31:0] exp_addr);
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        check({tag, "_req"}, req, 1);
        check({tag, "_addr"}, addr, exp_addr);
        check({tag, "_busy_req"}, busy, 1);
        for (int k = 0; k < gnt_wait; k++) begin
            step();
            check({tag, "_req_hold"}, req, 1);
            check({tag, "_addr_hold"}, addr, exp_addr);
            check({tag, "_busy_hold"}, busy, 1);
        end
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        check({tag, "_req_wait"}, req, 0);
        check({tag, "_busy_wait"}, busy, 1);
        for (int k = 0; k < rv_wait; k++) begin
            step();
            check({tag, "_busy_rv"}, busy, 1);
            check({tag, "_novalid_rv"}, valid, 0);
        end
        rvalid = 1'b1;
        rdata  = data;
        sb.push_back('{instr: data, pc: exp_addr});
        step();
        rvalid = 1'b0;
        check({tag, "_valid"}, valid, 1);
        check({tag, "_busy_done"}, busy, 0);
        check({tag, "_instr"}, instr, data);
        check({tag, "_pc"}, pc, exp_addr);
        check({tag, "_next_addr"}, addr, exp_addr + 32'd4);
    endtask

    initial begin
        vecs[0] = '{gnt_wait: 0, rv_wait: 0, rdata: 32'h0050_0093, exp_addr: 32'h0000_0000};
        vecs[1] = '{gnt_wait: 3, rv_wait: 0, rdata: 32'h00A0_0113, exp_addr: 32'h0000_0004};
        vecs[2] = '{gnt_wait: 0, rv_wait: 2, rdata: 32'h0020_81B3, exp_addr: 32'h0000_0008};
        vecs[3] = '{gnt_wait: 2, rv_wait: 1, rdata: 32'hFFFF_FFFF, exp_addr: 32'h0000_000C};

        rstn = 1'b0; fetch_en = 1'b0; redirect = 1'b0; redirect_addr = '0;
        gnt = 1'b0; rvalid = 1'b0; rdata = '0;
        w_rstn = 1'b0; w_fetch_en = 1'b0; w_redirect = 1'b0; w_redirect_addr = '0;
        w_gnt = 1'b0; w_rvalid = 1'b0; w_rdata = '0;
        step();
        step();
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_pc", pc, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_req", req, 0);
        check("rst_addr", addr, 0);
        check("rst_misaligned", misaligned, 0);
        rstn = 1'b1;
        w_rstn = 1'b1;
        step();

        for (int i = 0; i < 4; i++) begin
            do_fetch($sformatf("vec%0d", i), vecs[i].gnt_wait, vecs[i].rv_wait,
                     vecs[i].rdata, vecs[i].exp_addr);
        end

        // Redirect in WAIT, then the stale response must be dropped.
        fetch_en = 1'b1; step(); fetch_en = 1'b0;
        gnt = 1'b1; step(); gnt = 1'b0;
        redirect = 1'b1; redirect_addr = 32'h0000_0100; step(); redirect = 1'b0;
        check("A_disc_busy", busy, 1);
        check("A_disc_req", req, 0);
        check("A_disc_addr", addr, 32'h0000_0100);
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF; step(); rvalid = 1'b0;
        check("A_stale_valid", valid, 0);
        check("A_stale_busy", busy, 0);
        check("A_stale_instr", instr, 32'hFFFF_FFFF);
        rvalid = 1'b1; rdata = 32'h0BAD_F00D; step(); rvalid = 1'b0;
        check("A_idle_rvalid", valid, 0);
        check("A_idle_busy", busy, 0);
        do_fetch("A_refetch", 1, 0, 32'h0000_0513, 32'h0000_0100);

        // Redirect coinciding with rvalid in WAIT.
        fetch_en = 1'b1; step(); fetch_en = 1'b0;
        gnt = 1'b1; step(); gnt = 1'b0;
        redirect = 1'b1; redirect_addr = 32'h0000_0200;
        rvalid = 1'b1; rdata = 32'h1111_1111; step();
        redirect = 1'b0; rvalid = 1'b0;
        check("B_drop_valid", valid, 0);
        check("B_drop_busy", busy, 0);
        check("B_drop_addr", addr, 32'h0000_0200);
        check("B_drop_instr", instr, 32'h0000_0513);

        // Redirects in REQ (no gnt, then with gnt) and in DISCARD.
        fetch_en = 1'b1; step(); fetch_en = 1'b0;
        check("B_req_addr", addr, 32'h0000_0200);
        redirect = 1'b1; redirect_addr = 32'h0000_0300; step();
        check("B_req_redir_req", req, 1);
        check("B_req_redir_addr", addr, 32'h0000_0300);
        redirect_addr = 32'h0000_0400; gnt = 1'b1; step(); gnt = 1'b0;
        check("B_gnt_redir_req", req, 0);
        check("B_gnt_redir_busy", busy, 1);
        check("B_gnt_redir_addr", addr, 32'h0000_0400);
        redirect_addr = 32'h0000_0480; step(); redirect = 1'b0;
        check("B_disc_redir_busy", busy, 1);
        check("B_disc_redir_addr", addr, 32'h0000_0480);
        rvalid = 1'b1; rdata = 32'h2222_2222; step(); rvalid = 1'b0;
        check("B_disc_drop_valid", valid, 0);
        check("B_disc_drop_busy", busy, 0);
        do_fetch("B_after", 0, 1, 32'h1234_5678, 32'h0000_0480);

        // Redirect wins over fetch_en in IDLE.
        redirect = 1'b1; redirect_addr = 32'h0000_0600; fetch_en = 1'b1; step();
        redirect = 1'b0; fetch_en = 1'b0;
        check("prio_req", req, 0);
        check("prio_busy", busy, 0);
        check("prio_addr", addr, 32'h0000_0600);

`ifdef BETA_FETCH_MISALIGN_CHECK_EN
        redirect = 1'b1; redirect_addr = 32'h0000_0102; step(); redirect = 1'b0;
        check("mis_flag_set", misaligned, 1);
        check("mis_addr", addr, 32'h0000_0100);
        fetch_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("mis_blocked_req", req, 0);
            check("mis_blocked_busy", busy, 0);
            check("mis_flag_hold", misaligned, 1);
        end
        redirect = 1'b1; redirect_addr = 32'h0000_0104; step();
        redirect = 1'b0; fetch_en = 1'b0;
        check("mis_flag_clr", misaligned, 0);
        check("mis_clr_addr", addr, 32'h0000_0104);
        do_fetch("mis_fetch", 0, 0, 32'h0010_0093, 32'h0000_0104);
`else
        redirect = 1'b1; redirect_addr = 32'h0000_0502; step(); redirect = 1'b0;
        check("align_addr", addr, 32'h0000_0500);
        check("align_no_flag", misaligned, 0);
`endif

        // PC wrap at the top of the address space.
        redirect = 1'b1; redirect_addr = 32'hFFFF_FFFC; step(); redirect = 1'b0;
        do_fetch("wrap", 0, 0, 32'h0000_AAAA, 32'hFFFF_FFFC);

        // Asynchronous reset in WAIT, then a late response must be ignored.
        redirect = 1'b1; redirect_addr = 32'h0000_0700; step(); redirect = 1'b0;
        fetch_en = 1'b1; step(); fetch_en = 1'b0;
        gnt = 1'b1; step(); gnt = 1'b0;
        check("rstw_busy_before", busy, 1);
        #2 rstn = 1'b0;
        #1;
        check("rstw_req", req, 0);
        check("rstw_busy", busy, 0);
        check("rstw_addr", addr, 32'h0000_0000);
        check("rstw_instr", instr, 32'h0000_0013);
        check("rstw_valid", valid, 0);
        @(posedge clk);
        #1 rstn = 1'b1;
        rvalid = 1'b1; rdata = 32'h0000_0BAD; step(); rvalid = 1'b0;
        check("rstw_late_valid", valid, 0);
        check("rstw_late_instr", instr, 32'h0000_0013);
        check("rstw_late_busy", busy, 0);
        do_fetch("post_rst", 0, 0, 32'h0010_0073, 32'h0000_0000);

        // Second instance booting at the last word.
        check("w_boot_addr", w_addr, 32'hFFFF_FFFC);
        w_fetch_en = 1'b1; step(); w_fetch_en = 1'b0;
        check("w_req", w_req, 1);
        w_gnt = 1'b1; step(); w_gnt = 1'b0;
        w_rvalid = 1'b1; w_rdata = 32'hCAFE_0013; step(); w_rvalid = 1'b0;
        check("w_valid", w_valid, 1);
        check("w_pc", w_pc, 32'hFFFF_FFFC);
        check("w_instr", w_instr, 32'hCAFE_0013);
        check("w_next_addr", w_addr, 32'h0000_0000);

        step();
        step();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
